// File: rtl/decoder_scan_seq.sv
// Channel scan sequencer driving a 3-to-8 decoder (A/B/C select, G1/G2A_L/G2B_L enables).
// Ports: clock, reset, start, stop, mode, dwell[7:0], skip[7:0] in; a, b, c, g1, g2a_l, g2b_l, busy, done out.
module decoder_scan_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [7:0] dwell,
  input  logic [7:0] skip,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       g1,
  output logic       g2a_l,
  output logic       g2b_l,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] chan;
  logic [2:0] chan_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       mode_q;
  logic [7:0] dwell_q;
  logic [7:0] skip_q;
  logic       latch;
  logic       done_n;

  logic [7:0] dwell_eff;
  logic [2:0] first_in;
  logic [2:0] first_q;
  logic [2:0] next_hi;
  logic       has_hi;

  // A zero dwell still shows each channel for one cycle.
  assign dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;

  // Channel search: lowest clear bit of the incoming mask (for start),
  // lowest clear bit of the latched mask (for wrap), and the next clear
  // bit above the current channel (for advance). Downward loops leave
  // the lowest match as the final assignment.
  always_comb begin
    first_in = 3'd0;
    first_q  = 3'd0;
    next_hi  = 3'd0;
    has_hi   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!skip[i]) begin
        first_in = 3'(i);
      end
      if (!skip_q[i]) begin
        first_q = 3'(i);
      end
      if (!skip_q[i] && (i > int'(chan))) begin
        next_hi = 3'(i);
        has_hi  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    chan_n  = chan;
    cnt_n   = cnt;
    latch   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop && (skip != 8'hFF)) begin
          state_n = ACTIVE;
          chan_n  = first_in;
          cnt_n   = dwell_eff;
          latch   = 1'b1;
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (cnt == 8'd1) begin
          if (has_hi) begin
            chan_n = next_hi;
            cnt_n  = dwell_q;
          end else if (mode_q) begin
            chan_n = first_q;
            cnt_n  = dwell_q;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they move on
  // the same edge as the state/channel they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      chan    <= 3'd0;
      cnt     <= 8'd0;
      mode_q  <= 1'b0;
      dwell_q <= 8'd1;
      skip_q  <= 8'h00;
      a       <= 1'b0;
      b       <= 1'b0;
      c       <= 1'b0;
      g1      <= 1'b0;
      g2a_l   <= 1'b1;
      g2b_l   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      chan  <= chan_n;
      cnt   <= cnt_n;
      if (latch) begin
        mode_q  <= mode;
        dwell_q <= dwell_eff;
        skip_q  <= skip;
      end
      a     <= (state_n == ACTIVE) ? chan_n[0] : 1'b0;
      b     <= (state_n == ACTIVE) ? chan_n[1] : 1'b0;
      c     <= (state_n == ACTIVE) ? chan_n[2] : 1'b0;
      g1    <= (state_n == ACTIVE);
      g2a_l <= (state_n != ACTIVE);
      g2b_l <= (state_n != ACTIVE);
      busy  <= (state_n == ACTIVE);
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: a schedule-list model predicts
// every cycle's outputs; a monitor pops and compares each cycle.
module tb_decoder_scan_seq;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic [7:0] skip;
  logic       a;
  logic       b;
  logic       c;
  logic       g1;
  logic       g2a_l;
  logic       g2b_l;
  logic       busy;
  logic       done;

  decoder_scan_seq dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dwell (dwell),
    .skip  (skip),
    .a     (a),
    .b     (b),
    .c     (c),
    .g1    (g1),
    .g2a_l (g2a_l),
    .g2b_l (g2b_l),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected vector: {done, busy, g1, g2a_l, g2b_l, c, b, a}
  logic [7:0] exp_q[$];

  // Model: an active scan is a list of channel values, one per cycle.
  bit         m_active = 0;
  logic [2:0] m_pend[$];
  bit         m_mode = 0;
  int         m_dw   = 1;
  logic [7:0] m_skip = 8'h00;

  function automatic void build_pass();
    for (int ch = 0; ch < 8; ch++)
      if (!m_skip[ch])
        for (int k = 0; k < m_dw; k++) m_pend.push_back(3'(ch));
  endfunction

  function automatic logic [7:0] v_idle(input bit d);
    return {d, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000};
  endfunction

  function automatic logic [7:0] v_act(input logic [2:0] ch);
    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ch};
  endfunction

  function automatic logic [7:0] model_step(
    input bit r, input bit s, input bit p,
    input bit md, input logic [7:0] d, input logic [7:0] k);
    logic [7:0] e;
    if (r) begin
      m_active = 0;
      m_pend.delete();
      m_mode = 0; m_dw = 1; m_skip = 8'h00;
      e = v_idle(0);
    end else if (!m_active) begin
      if (s && !p && k != 8'hFF) begin
        m_mode = md;
        m_dw = (d == 0) ? 1 : int'(d);
        m_skip = k;
        m_pend.delete();
        build_pass();
        m_active = 1;
        e = v_act(m_pend.pop_front());
      end else begin
        e = v_idle(0);
      end
    end else if (p) begin
      m_active = 0;
      m_pend.delete();
      e = v_idle(0);
    end else if (m_pend.size() == 0) begin
      if (m_mode) begin
        build_pass();
        e = v_act(m_pend.pop_front());
      end else begin
        m_active = 0;
        e = v_idle(1);
      end
    end else begin
      e = v_act(m_pend.pop_front());
    end
    return e;
  endfunction

  task automatic step(input bit r, input bit s, input bit p,
                      input bit md, input logic [7:0] d,
                      input logic [7:0] k);
    reset = r; start = s; stop = p;
    mode = md; dwell = d; skip = k;
    exp_q.push_back(model_step(r, s, p, md, d, k));
    @(posedge clock);
    #2;
  endtask

  // Idle/hold cycle with scrambled parameter inputs.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Monitor
  initial begin
    logic [7:0] e;
    logic [7:0] got;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {done, busy, g1, g2a_l, g2b_l, c, b, a};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d got=%b expected=%b (done busy g1 g2a g2b c b a)",
                   cyc, got, e);
        end
      end
    end
  end

  initial begin
    int sel;
    logic [7:0] k;
    // Reset state
    step(1, 0, 0, 0, 8'd0, 8'd0);
    step(1, 1, 0, 1, 8'd5, 8'd0);
    step(0, 0, 0, 0, 8'd0, 8'd0);
    // One-shot full scan, dwell 2
    step(0, 1, 0, 0, 8'd2, 8'h00);
    hold(20);
    // Skip odd channels, zero dwell
    step(0, 1, 0, 0, 8'd0, 8'b10101010);
    hold(8);
    // Continuous wrap over ch0/ch7, then stop
    step(0, 1, 0, 1, 8'd3, 8'b01111110);
    hold(20);
    step(0, 0, 1, 0, 8'd0, 8'd0);
    hold(4);
    // All-skipped start ignored; start+stop stays idle
    step(0, 1, 0, 0, 8'd2, 8'hFF);
    hold(3);
    step(0, 1, 1, 0, 8'd2, 8'h00);
    hold(3);
    // Start during active ignored
    step(0, 1, 0, 0, 8'd3, 8'h00);
    hold(2);
    step(0, 1, 0, 1, 8'd7, 8'hF0);
    hold(28);
    // Reset at 2nd cycle of ch3, dwell 4
    step(0, 1, 0, 0, 8'd4, 8'h00);
    hold(13);
    step(1, 0, 0, 0, 8'd4, 8'h00);
    hold(10);
    // Single-channel continuous hold
    step(0, 1, 0, 1, 8'd2, 8'b11011111);
    hold(9);
    step(0, 0, 1, 0, 8'd0, 8'd0);
    hold(2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: k = 8'($urandom);
        1: k = 8'hFF;
        2: k = ~(8'd1 << $urandom_range(0, 7));
        default: k = 8'h00;
      endcase
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0,
           1'($urandom),
           8'($urandom_range(0, 4)),
           k);
    end
    step(1, 0, 0, 0, 8'd0, 8'd0);
    hold(2);
    @(posedge clock);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLOCK  input  1  rising-edge clock for all state.
REQ-002 RESET  input  1  synchronous active-high reset, sampled on the CLOCK rising edge.
REQ-003 START  input  1  single-cycle request to begin a scan; sampled in IDLE only.
REQ-004 STOP  input  1  abort request; forces return to IDLE.
REQ-005 MODE  input  1  0 = one-shot scan, 1 = continuous scan; latched at START.
REQ-006 DWELL  input  8  number of cycles per channel; latched at START; value 0 is treated as 1.
REQ-007 SKIP  input  8  per-channel skip mask, bit i=1 skips channel i; latched at START.
REQ-008 A, B, C  output  1 each  registered channel select to the downstream 3-to-8 decoder, with A as LSB.
REQ-009 G1  output  1  active-high decoder enable; G2A_L, G2B_L  output  1 each  active-low decoder enables.
REQ-010 BUSY  output  1  high while in ACTIVE; DONE  output  1  single-cycle pulse at the end of a one-shot scan.

Function
REQ-011 FSM states SHALL be IDLE and ACTIVE only, held in a registered state variable.
REQ-012 In IDLE, START=1, STOP=0 and SKIP!=8'hFF SHALL cause the following on the next edge: latch MODE, DWELL and SKIP; load channel = lowest index with SKIP bit 0; load dwell counter = max(DWELL,1); enter ACTIVE.
REQ-013 START with SKIP==8'hFF SHALL be ignored: remain IDLE, no DONE.
REQ-014 START and STOP together in IDLE: STOP SHALL win; remain IDLE.
REQ-015 START while in ACTIVE SHALL be ignored, and the latched parameters SHALL NOT change.
REQ-016 In ACTIVE, the dwell counter SHALL decrement each cycle; the cycle with counter==1 is the last cycle of the current channel.
REQ-017 On the last cycle, the channel SHALL advance to the next higher unskipped index, with the counter reloaded to max(DWELL,1).
REQ-018 If no higher unskipped index exists: in MODE=0, enter IDLE; in MODE=1, wrap to the lowest unskipped index.
REQ-019 Each unskipped channel SHALL be presented for exactly max(DWELL,1) consecutive cycles; skipped channels SHALL never appear on A/B/C.
REQ-020 The channel search SHALL be combinational over the latched SKIP mask, giving zero dead cycles between channels.
REQ-021 A/B/C, G1, G2A_L, G2B_L and BUSY SHALL be registered and change only with state/channel, aligned to the same edge.
REQ-022 In ACTIVE: G1=1, G2A_L=0, G2B_L=0, BUSY=1, and {C,B,A} = current channel.
REQ-023 In IDLE: G1=0, G2A_L=1, G2B_L=1, BUSY=0, and {C,B,A}=3'b000.
REQ-024 DONE SHALL be 1 for exactly the first IDLE cycle following normal one-shot completion, and 0 otherwise.
REQ-025 STOP=1 in ACTIVE SHALL force IDLE on the next edge, with no DONE; STOP SHALL take priority over channel advance.
REQ-026 A single-channel mask with MODE=1 SHALL hold that channel continuously, with the counter reloading every max(DWELL,1) cycles.

Reset
REQ-027 RESET=1 SHALL force IDLE on the next edge regardless of state, including mid-dwell; it SHALL have priority over START and STOP.
REQ-028 After reset: A=B=C=0, G1=0, G2A_L=1, G2B_L=1, BUSY=0, DONE=0, latched registers cleared (SKIP latched = 8'h00, DWELL latched = 1, MODE latched = 0).
REQ-029 No DONE pulse SHALL follow a reset-terminated scan.

Verification
REQ-030 One-shot: SKIP=8'h00, DWELL=2, MODE=0, START pulse -> channels 0..7 for 2 cycles each (16 ACTIVE cycles), then IDLE with DONE=1 for one cycle.
REQ-031 Skip/zero dwell: SKIP=8'b10101010, DWELL=0, MODE=0 -> {C,B,A} = 0,2,4,6 for 1 cycle each, then DONE.
REQ-032 Continuous wrap: SKIP=8'b01111110, DWELL=3, MODE=1 -> ch0 x3, ch7 x3, ch0 x3, and so on; DONE never asserts; STOP -> IDLE next edge, outputs at idle values.
REQ-033 Illegal/priority: SKIP=8'hFF with START -> BUSY stays 0, no DONE. START and STOP in the same cycle -> stays IDLE. START during ACTIVE with new DWELL -> dwell unchanged.
REQ-034 Reset mid-scan: RESET asserted at the 2nd cycle of ch3 (DWELL=4) -> next edge shows idle values (REQ-028), with no DONE afterward.
REQ-035 Parameter latch: change SKIP and DWELL mid-scan -> the sequence follows the values latched at START.
